// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encodings,
// default parameter values and the compile-time sizing helpers.
package pulse_stretch_pkg;

  localparam int unsigned DEF_WIDTH = 32'd4;
  localparam int unsigned DEF_GAP   = 32'd2;
  localparam int unsigned DEF_QW    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Ceiling log2, with a floor of one bit so a counter is never zero-width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Largest of three unsigned values, used to size the phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pulse_stretch_phase_timer.sv
// Loadable down-counter that times one HIGH or GAP phase.
// done is asserted while the count sits at zero (the last cycle of a phase).
module phase_timer #(
  parameter int unsigned TW = 32'd2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: a load takes priority, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {TW{1'b0}})) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/pulse_stretch.sv
// Pulse-to-level converter. Each request pulse is replayed as a WIDTH-cycle
// high level followed by a GAP-cycle low; requests that arrive during a
// replay wait in a saturating pending counter and are launched in order.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GAP   = DEF_GAP,
  parameter int unsigned QW    = DEF_QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  input  logic          clr_ovf,
  output logic          level_out,
  output logic          busy,
  output logic [QW-1:0] pending,
  output logic          overflow
);

  localparam int unsigned   TW       = clog2(max3(WIDTH, GAP, 32'd2));
  localparam bit            HAS_GAP  = (GAP != 32'd0);
  localparam logic [TW-1:0] LD_HIGH  = TW'(WIDTH - 32'd1);
  localparam logic [TW-1:0] LD_GAP   = HAS_GAP ? TW'(GAP - 32'd1) : {TW{1'b0}};
  localparam logic [QW-1:0] PEND_MAX = {QW{1'b1}};

  state_e        state_q;
  state_e        state_d;
  logic          level_q;
  logic          busy_q;
  logic [QW-1:0] pending_q;
  logic [QW-1:0] pending_d;
  logic          overflow_q;
  logic          overflow_d;

  logic          req_s;
  logic          launch_s;
  logic          drop_s;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_en_s;
  logic          tmr_done_s;

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .done     (tmr_done_s)
  );

  // Phase sequencing: decide the next state, launches and timer control.
  always_comb begin
    req_s      = pulse_in | (pending_q != {QW{1'b0}});
    state_d    = state_q;
    launch_s   = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = LD_HIGH;
    tmr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d    = ST_HIGH;
          launch_s   = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (!tmr_done_s) begin
          tmr_en_s = 1'b1;
        end else if (HAS_GAP) begin
          state_d    = ST_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = LD_GAP;
        end else if (req_s) begin
          state_d    = ST_HIGH;
          launch_s   = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!tmr_done_s) begin
          tmr_en_s = 1'b1;
        end else if (req_s) begin
          state_d    = ST_HIGH;
          launch_s   = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending count and sticky overflow; a drop beats a simultaneous clear.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    drop_s     = 1'b0;
    if (pulse_in && !launch_s) begin
      if (pending_q == PEND_MAX) begin
        drop_s = 1'b1;
      end else begin
        pending_d = pending_q + QW'(1);
      end
    end else if (!pulse_in && launch_s) begin
      pending_d = pending_q - QW'(1);
    end else begin
      pending_d = pending_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, registered outputs and counters, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= {QW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= (state_d == ST_HIGH);
      busy_q     <= (state_d != ST_IDLE);
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: three configurations share one
// stimulus stream; a timeline reference model predicts each cycle's outputs.
`timescale 1ns/1ps
module tb_pulse_stretch;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse_in = 1'b0;
  logic clr_ovf = 1'b0;
  logic [NI-1:0] lvl_s;
  logic [NI-1:0] bsy_s;
  logic [NI-1:0] ovf_s;
  logic [3:0] pend0_s;
  logic [3:0] pend1_s;
  logic [1:0] pend2_s;

  always #5 clk = ~clk;

  pulse_stretch #(.WIDTH(4), .GAP(2), .QW(4)) dut0 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .level_out(lvl_s[0]), .busy(bsy_s[0]), .pending(pend0_s), .overflow(ovf_s[0]));
  pulse_stretch #(.WIDTH(3), .GAP(0), .QW(4)) dut1 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .level_out(lvl_s[1]), .busy(bsy_s[1]), .pending(pend1_s), .overflow(ovf_s[1]));
  pulse_stretch #(.WIDTH(4), .GAP(2), .QW(2)) dut2 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .level_out(lvl_s[2]), .busy(bsy_s[2]), .pending(pend2_s), .overflow(ovf_s[2]));

  function automatic int cfg_w(input int k);
    case (k)
      0: return 4;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_g(input int k);
    case (k)
      0: return 2;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_q(input int k);
    case (k)
      0: return 4;
      1: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] pend_act(input int k);
    case (k)
      0: return pend0_s;
      1: return pend1_s;
      default: return {2'b00, pend2_s};
    endcase
  endfunction

  typedef struct {
    int cyc;
    logic [NI-1:0] lvl;
    logic [NI-1:0] bsy;
    logic [NI-1:0] ovf;
    logic [NI-1:0][3:0] pend;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: requests waiting, earliest cycle a new launch may be
  // decided, cycle of the latest launch, sticky overflow.
  int m_pend [NI];
  int m_next [NI];
  int m_last [NI];
  bit m_ovf [NI];

  // Advance the model by one clock cycle and queue the outputs expected after that edge.
  task automatic step(input bit p, input bit c, input bit r);
    exp_t e;
    e.cyc = cyc;
    for (int k = 0; k < NI; k++) begin
      int w;
      int g;
      int mx;
      bit launch;
      bit dropped;
      w = cfg_w(k);
      g = cfg_g(k);
      mx = (1 << cfg_q(k)) - 1;
      if (!r) begin
        m_pend[k] = 0;
        m_ovf[k] = 1'b0;
        m_last[k] = -1000;
        m_next[k] = cyc + 1;
      end else begin
        launch = (cyc >= m_next[k]) && ((m_pend[k] > 0) || p);
        dropped = p && !launch && (m_pend[k] == mx);
        if (launch) begin
          m_last[k] = cyc;
          m_next[k] = cyc + w + g;
        end
        if (p && !launch && !dropped) m_pend[k] = m_pend[k] + 1;
        else if (!p && launch) m_pend[k] = m_pend[k] - 1;
        if (dropped) m_ovf[k] = 1'b1;
        else if (c) m_ovf[k] = 1'b0;
      end
      e.lvl[k] = ((cyc + 1) >= (m_last[k] + 1)) && ((cyc + 1) <= (m_last[k] + w));
      e.bsy[k] = ((cyc + 1) >= (m_last[k] + 1)) && ((cyc + 1) <= (m_last[k] + w + g));
      e.ovf[k] = m_ovf[k];
      e.pend[k] = 4'(m_pend[k]);
    end
    sb_q.push_back(e);
    cyc++;
  endtask

  task automatic drive(input bit p, input bit c, input bit r);
    @(negedge clk);
    pulse_in = p;
    clr_ovf = c;
    rst = r;
    step(p, c, r);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input int k, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, c, act, exp);
    end
  endtask

  // Monitor: one output set per clock; compare it with the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        chk("level_out", k, e.cyc, 32'(lvl_s[k]), 32'(e.lvl[k]));
        chk("busy", k, e.cyc, 32'(bsy_s[k]), 32'(e.bsy[k]));
        chk("pending", k, e.cyc, 32'(pend_act(k)), 32'(e.pend[k]));
        chk("overflow", k, e.cyc, 32'(ovf_s[k]), 32'(e.ovf[k]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dens;
    bit p;
    bit c;
    bit r;
    for (int k = 0; k < NI; k++) begin
      m_pend[k] = 0;
      m_next[k] = 0;
      m_last[k] = -1000;
      m_ovf[k] = 1'b0;
    end
    // reset
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    // single pulse
    drive(1'b1, 1'b0, 1'b1);
    idle(12);
    // burst of three
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    idle(25);
    // five back-to-back requests: saturates the narrow counter
    repeat (5) drive(1'b1, 1'b0, 1'b1);
    idle(45);
    // clear alone
    drive(1'b0, 1'b1, 1'b1);
    idle(2);
    // refill, then clear coinciding with a drop, then clear alone
    repeat (5) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    idle(60);
    // reset in the middle of a HIGH phase with requests queued
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    idle(20);
    // randomized segments with varying request density
    for (int s = 0; s < 20; s++) begin
      dens = $urandom_range(0, 100);
      repeat (150) begin
        p = ($urandom_range(0, 99) < dens);
        c = ($urandom_range(0, 29) == 0);
        r = ($urandom_range(0, 299) != 0);
        drive(p, c, r);
      end
    end
    idle(3);
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Pulse-to-level converter: accepts single-cycle request pulses (as produced by the rising-edge pulse maker) and replays each one as a registered output level held high for WIDTH cycles, followed by a mandatory low GAP. Requests that arrive while an output pulse is in progress are counted in a saturating pending counter and replayed in order, so no pulse is lost until the counter saturates. It sits on the output side of control paths: LED/strobe drivers, external enables and slow-domain handshakes that need a minimum high and low time.

## Interface
- WIDTH, 4: output high time in cycles; legal range ≥1.
- GAP, 2: forced low time between consecutive output pulses in cycles; legal range ≥0.
- QW, 4: pending counter width; maximum pending count is 2^QW−1.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- pulse_in  in  1  request; each cycle it is high counts as one request.
- clr_ovf  in  1  clears the overflow flag.
- level_out  out  1  stretched output; registered.
- busy  out  1  high when state ≠ IDLE.
- pending  out  QW  count of queued requests not yet launched.
- overflow  out  1  sticky; set when a request is dropped.

## Operation
- States: IDLE, HIGH, GAP. A phase timer counts down within HIGH and GAP.
- Request available: req = pulse_in | (pending ≠ 0).
- IDLE: if req, go to HIGH and load the timer with WIDTH−1. This is a launch.
- HIGH: level_out = 1. On the last HIGH cycle, go to GAP with the timer loaded to GAP−1 when GAP > 0. When GAP = 0, go to HIGH (a launch) if req, otherwise go to IDLE.
- GAP: level_out = 0. On the last GAP cycle, go to HIGH (a launch) if req, otherwise go to IDLE.
- Pending update: pending_next = pending + pulse_in − launch, with these rules:
  - A launch consumes pulse_in when pending = 0.
  - pulse_in together with a launch leaves pending unchanged, including when pending is at maximum.
- Overflow: pending = max, pulse_in = 1 and no launch → the request is dropped and overflow is set.
- clr_ovf clears overflow. If clr_ovf coincides with a new drop, the set wins.
- All width arithmetic is unsigned. The timer width is clog2(max(WIDTH, GAP, 2)).

## Timing
- Reset (rst = 0 at a clk edge) forces state = IDLE, level_out = 0, busy = 0, pending = 0, overflow = 0, and resets the timer.
- Reset mid-operation:
  - level_out drops after that edge.
  - Queued requests are discarded.
  - pulse_in is ignored while rst = 0.
- Latency: pulse_in high in cycle n with the block in IDLE → level_out high in cycles n+1 … n+WIDTH and low in cycles n+WIDTH+1 … n+WIDTH+GAP. The earliest next rise is at cycle n+WIDTH+GAP+1.
- Minimum output period is WIDTH+GAP cycles. With GAP = 0, back-to-back launches hold level_out continuously high.
- busy follows state registered in the same edge as level_out. pending and overflow update on the same edge as the request that changes them.

## Structure
- Shared package holds:
  - state encodings ST_IDLE, ST_HIGH, ST_GAP;
  - the clog2 helper function;
  - default constants for WIDTH, GAP and QW.
- One sub-module, phase_timer:
  - loadable down-counter, parameterised by width;
  - inputs load, load_val and en; output done (count = 0);
  - shares the same clk and rst.
- Top level contains the FSM, the pending counter and the overflow logic.

## Test plan
- Single pulse: WIDTH=4, GAP=2, pulse_in at cycle 0 → level_out = 1 for cycles 1–4, then 0. busy = 1 for cycles 1–6, pending stays 0.
- Burst: pulse_in at cycles 0, 1, 2 → pending = 1 after cycle 1 and 2 after cycle 2. level_out is high for cycles 1–4, 7–10 and 13–16. pending returns to 0 after the launch at cycle 12.
- Overflow: QW=2, pulse_in for cycles 0–4 → pending saturates at 3 after cycle 3 and overflow = 1 after cycle 4. Exactly 4 output pulses are produced.
- Clear race: overflow set; clr_ovf = 1 alone → overflow = 0. clr_ovf coinciding with a new drop → overflow stays 1.
- GAP=0, WIDTH=3: pulse_in at cycles 0 and 1 → level_out continuously high for cycles 1–6, then 0 at cycle 7.
- Reset mid-HIGH: pending = 2, rst = 0 at cycle 3 → level_out, busy, pending and overflow are all 0 from cycle 4. After rst returns to 1 with no further pulse_in, no further pulses are output.
